// File: rtl/regfile_writeback_if.sv
// Writeback bus between the pipeline, regfile_writeback and the register file ports.
// master = regfile_writeback side, slave = pipeline/regfile environment side.
interface regfile_writeback_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 3
);
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_address;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              hold;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_write_address;
  logic [DATA_W-1:0] rf_write_data;
  logic [ADDR_W-1:0] rd_address_1;
  logic [ADDR_W-1:0] rd_address_2;
  logic [DATA_W-1:0] rf_read_data_1;
  logic [DATA_W-1:0] rf_read_data_2;
  logic [DATA_W-1:0] rd_data_1;
  logic [DATA_W-1:0] rd_data_2;
  logic              pending;
  logic [CNT_W-1:0]  count;

  modport master (
    input  wb_valid, wb_address, wb_data, hold,
    input  rd_address_1, rd_address_2, rf_read_data_1, rf_read_data_2,
    output wb_ready, rf_write, rf_write_address, rf_write_data,
    output rd_data_1, rd_data_2, pending, count
  );

  modport slave (
    output wb_valid, wb_address, wb_data, hold,
    output rd_address_1, rd_address_2, rf_read_data_1, rf_read_data_2,
    input  wb_ready, rf_write, rf_write_address, rf_write_data,
    input  rd_data_1, rd_data_2, pending, count
  );
endinterface

// File: rtl/regfile_writeback.sv
// In-order writeback queue draining one register-file write per cycle.
// Define REGFILE_WB_BYPASS_EN to forward still-queued writes to the decode read ports.
module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_writeback_if.master  bus
);
  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Queue storage carries data only, so it is left out of reset.
  logic [ADDR_W-1:0] entry_addr_q [DEPTH];
  logic [DATA_W-1:0] entry_data_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rf_write_q, rf_write_d;
  logic [ADDR_W-1:0] rf_write_address_q, rf_write_address_d;
  logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;
  logic              push;
  logic              pop;

  always_comb begin
    push               = bus.wb_valid && (count_q != FULL_CNT);
    pop                = (count_q != '0) && !bus.hold;
    head_d             = head_q;
    tail_d             = tail_q;
    count_d            = count_q;
    rf_write_d         = pop;
    rf_write_address_d = rf_write_address_q;
    rf_write_data_d    = rf_write_data_q;
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d             = head_q + PTR_W'(1);
      rf_write_address_d = entry_addr_q[head_q];
      rf_write_data_d    = entry_data_q[head_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      rf_write_q         <= 1'b0;
      rf_write_address_q <= '0;
      rf_write_data_q    <= '0;
    end else begin
      head_q             <= head_d;
      tail_q             <= tail_d;
      count_q            <= count_d;
      rf_write_q         <= rf_write_d;
      rf_write_address_q <= rf_write_address_d;
      rf_write_data_q    <= rf_write_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr_q[tail_q] <= bus.wb_address;
      entry_data_q[tail_q] <= bus.wb_data;
    end
  end

  assign bus.wb_ready         = (count_q != FULL_CNT);
  assign bus.pending          = (count_q != '0);
  assign bus.count            = count_q;
  assign bus.rf_write         = rf_write_q;
  assign bus.rf_write_address = rf_write_address_q;
  assign bus.rf_write_data    = rf_write_data_q;

`ifdef REGFILE_WB_BYPASS_EN
  logic [PTR_W-1:0] scan_idx;

  // Walk oldest to youngest so the last hit is the youngest matching entry.
  always_comb begin
    bus.rd_data_1 = bus.rf_read_data_1;
    bus.rd_data_2 = bus.rf_read_data_2;
    scan_idx      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (entry_addr_q[scan_idx] == bus.rd_address_1) begin
          bus.rd_data_1 = entry_data_q[scan_idx];
        end
        if (entry_addr_q[scan_idx] == bus.rd_address_2) begin
          bus.rd_data_2 = entry_data_q[scan_idx];
        end
      end
    end
  end
`else
  logic unused_rd_address;

  assign unused_rd_address = ^{bus.rd_address_1, bus.rd_address_2};
  assign bus.rd_data_1     = bus.rf_read_data_1;
  assign bus.rd_data_2     = bus.rf_read_data_2;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: directed pushes queue expected writes,
// a negedge monitor matches every rf_write pulse against them in order.
module tb_regfile_writeback;
  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;
  logic [18:0] sb [$];

  regfile_writeback_if #(.ADDR_W(3), .DATA_W(16), .CNT_W(3)) bus ();

  regfile_writeback #(.DEPTH(4), .ADDR_W(3), .DATA_W(16), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs are applied 1ns after an edge, consumed by the next edge.
  task automatic drive(input logic v, input logic [2:0] a, input logic [15:0] d,
                       input logic h, input logic exp_acc);
    bus.wb_valid   = v;
    bus.wb_address = a;
    bus.wb_data    = d;
    bus.hold       = h;
    if (v && exp_acc) sb.push_back({a, d});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [18:0] exp_e;
    if (reset_n === 1'b1 && bus.rf_write === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write",
                 bus.rf_write_address, bus.rf_write_data);
      end else begin
        exp_e = sb.pop_front();
        chk("write_entry", {13'd0, bus.rf_write_address, bus.rf_write_data}, {13'd0, exp_e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset_n = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_address = '0; bus.wb_data = '0; bus.hold = 1'b0;
    bus.rd_address_1 = '0; bus.rd_address_2 = '0;
    bus.rf_read_data_1 = '0; bus.rf_read_data_2 = '0;
    @(posedge clk); #1;
    chk("rst_rf_write", {31'd0, bus.rf_write}, 32'd0);
    chk("rst_wr_addr", {29'd0, bus.rf_write_address}, 32'd0);
    chk("rst_wr_data", {16'd0, bus.rf_write_data}, 32'd0);
    chk("rst_count", {29'd0, bus.count}, 32'd0);
    chk("rst_pending", {31'd0, bus.pending}, 32'd0);
    chk("rst_ready", {31'd0, bus.wb_ready}, 32'd1);
    reset_n = 1'b1;

    // Single write: no same-edge pass-through, one pulse on the next edge.
    drive(1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b1);
    chk("single_count_1", {29'd0, bus.count}, 32'd1);
    chk("single_no_passthru", {31'd0, bus.rf_write}, 32'd0);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    chk("single_rf_write", {31'd0, bus.rf_write}, 32'd1);
    chk("single_addr", {29'd0, bus.rf_write_address}, 32'd3);
    chk("single_data", {16'd0, bus.rf_write_data}, 32'h0000BEEF);
    chk("single_count_0", {29'd0, bus.count}, 32'd0);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    chk("single_pulse_end", {31'd0, bus.rf_write}, 32'd0);
    chk("single_addr_hold", {29'd0, bus.rf_write_address}, 32'd3);

    // Fill under hold; fifth push is ignored.
    for (int i = 1; i <= 5; i++)
      drive(1'b1, 3'(i), 16'(i * 16'h0011), 1'b1, (i <= 4) ? 1'b1 : 1'b0);
    chk("full_count", {29'd0, bus.count}, 32'd4);
    chk("full_ready", {31'd0, bus.wb_ready}, 32'd0);
    chk("full_no_write", {31'd0, bus.rf_write}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
      chk("drain_count", {29'd0, bus.count}, 32'(3 - i));
      chk("drain_ready", {31'd0, bus.wb_ready}, 32'd1);
    end
    drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    chk("drain_done", {31'd0, bus.rf_write}, 32'd0);

    // Steady push/pop at count 2, wrapping the pointers.
    drive(1'b1, 3'd6, 16'hA000, 1'b1, 1'b1);
    drive(1'b1, 3'd7, 16'hA001, 1'b1, 1'b1);
    chk("steady_pre", {29'd0, bus.count}, 32'd2);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'(i % 8), 16'(16'h1000 + i), 1'b0, 1'b1);
      chk("steady_count", {29'd0, bus.count}, 32'd2);
      chk("steady_rf_write", {31'd0, bus.rf_write}, 32'd1);
    end
    drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    chk("steady_empty", {29'd0, bus.count}, 32'd0);

    // Read bypass of queued writes.
    drive(1'b1, 3'd2, 16'h1111, 1'b1, 1'b1);
    drive(1'b1, 3'd2, 16'h2222, 1'b1, 1'b1);
    bus.wb_valid = 1'b0;
    bus.rd_address_1 = 3'd2; bus.rf_read_data_1 = 16'h0000;
    bus.rd_address_2 = 3'd5; bus.rf_read_data_2 = 16'h5A5A;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("bypass_rd1_young", {16'd0, bus.rd_data_1}, 32'h00002222);
`else
    chk("bypass_rd1_raw", {16'd0, bus.rd_data_1}, 32'h00000000);
`endif
    chk("bypass_rd2_miss", {16'd0, bus.rd_data_2}, 32'h00005A5A);
    bus.rd_address_1 = 3'd3; bus.rf_read_data_1 = 16'h0303;
    bus.rd_address_2 = 3'd2; bus.rf_read_data_2 = 16'h7777;
    #1;
    chk("bypass_rd1_miss", {16'd0, bus.rd_data_1}, 32'h00000303);
`ifdef REGFILE_WB_BYPASS_EN
    chk("bypass_rd2_young", {16'd0, bus.rd_data_2}, 32'h00002222);
`else
    chk("bypass_rd2_raw", {16'd0, bus.rd_data_2}, 32'h00007777);
`endif
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    chk("bypass_drained", {29'd0, bus.count}, 32'd0);

    // Asynchronous reset in the middle of a drain.
    drive(1'b1, 3'd1, 16'hC001, 1'b1, 1'b1);
    drive(1'b1, 3'd2, 16'hC002, 1'b1, 1'b1);
    drive(1'b1, 3'd3, 16'hC003, 1'b1, 1'b1);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    chk("mid_rf_write", {31'd0, bus.rf_write}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_rf_write", {31'd0, bus.rf_write}, 32'd0);
    chk("mid_rst_count", {29'd0, bus.count}, 32'd0);
    chk("mid_rst_pending", {31'd0, bus.pending}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.wb_ready}, 32'd1);
    chk("mid_rst_addr", {29'd0, bus.rf_write_address}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    chk("post_rst_count", {29'd0, bus.count}, 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side initiator for the 8×16 register file. It buffers writeback requests from the execute/memory stages in a small in-order queue and drains them into the register file write port at one write per cycle. It also supplies read data to the decode stage with optional bypass of writes that are still queued. It sits between the pipeline writeback path and the register file's `write`/`write_address`/`write_data` and read-data ports.

## Interface
- `DEPTH`, 4 — queue entries; power of two, 2..16.
- `ADDR_W`, 3 — register address width.
- `DATA_W`, 16 — register data width.
- `CNT_W`, 3 — occupancy width; must equal clog2(DEPTH+1).

- `clk`  in  1  — single clock, rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `wb_valid`  in  1  — writeback request.
- `wb_address`  in  ADDR_W  — destination register.
- `wb_data`  in  DATA_W  — value to write.
- `wb_ready`  out  1  — queue can accept; equals `count != DEPTH`.
- `hold`  in  1  — inhibits draining, e.g. during a regfile dump.
- `rf_write`  out  1  — write strobe to the register file (registered).
- `rf_write_address`  out  ADDR_W  — registered write address.
- `rf_write_data`  out  DATA_W  — registered write data.
- `rd_address_1`, `rd_address_2`  in  ADDR_W  — decode read addresses, also wired to the regfile.
- `rf_read_data_1`, `rf_read_data_2`  in  DATA_W  — raw regfile read data.
- `rd_data_1`, `rd_data_2`  out  DATA_W  — read data delivered to decode.
- `pending`  out  1  — queue non-empty.
- `count`  out  CNT_W  — queue occupancy.

## Operation
- Circular FIFO with head pointer, tail pointer and occupancy counter. Pointers wrap modulo DEPTH.
- **Push:** on an edge where `wb_valid && wb_ready`, the entry {`wb_address`, `wb_data`} is written at the tail and the tail advances.
- **Pop:** on an edge where `count > 0 && !hold`, the head entry is loaded into the `rf_write_*` registers, `rf_write` is set to 1, and the head advances.
- **No pop:** on any other edge, `rf_write` is set to 0. `rf_write_address` and `rf_write_data` hold their previous values.
- **Push and pop on the same edge:** both are legal. The count is unchanged and the pointers advance independently.
- **Full:** `wb_ready = 0`. A `wb_valid` while full is ignored, with no error flag; the upstream stage must stall. A pop on that edge does not open a slot until the following cycle.
- **Empty:** nothing drains. A push into an empty queue is never passed straight through to `rf_write` on the same edge.
- **Ordering:** entries are written strictly in FIFO order. Duplicate addresses are not merged; each one is written in turn.
- **Address 0:** an ordinary register with no special handling.
- **`hold`:** freezes the head. Pushes continue until the queue is full.
- **Reset (asynchronous, any time):** clears the queue, discards pending writes, and forces `rf_write = 0`, `rf_write_address = 0`, `rf_write_data = 0`, `count = 0`, `pending = 0` and `wb_ready = 1`.

## Timing
- With the queue empty, a push at edge N drives `rf_write` high during cycle N+1→N+2, i.e. it is popped at edge N+1.
- Steady-state drain rate is one write per cycle.
- `rf_write` is high for exactly one cycle per entry.
- `wb_ready`, `pending` and `count` are combinational from registered state and update after each edge.
- The register file updates combinationally while `rf_write` is high. The entry currently in the `rf_write` register is therefore visible through `rf_read_data_x` and is not bypassed by this block.
- Bypass (see Configuration) is purely combinational from the queue contents and `rd_address_x`, with zero cycles of latency.

## Configuration
- Macro: `REGFILE_WB_BYPASS_EN`.
- **Defined:** `rd_data_x` returns the `wb_data` of the youngest valid queue entry whose address equals `rd_address_x`. If no entry matches, it returns `rf_read_data_x`. Ports 1 and 2 are resolved independently.
- **Undefined:** `rd_data_x = rf_read_data_x` unconditionally, and no comparators are built. Decode must then stall on `pending`.

## Test plan
- **Reset then single write:** release `reset_n`, push {addr 3, 16'hBEEF} at edge 1 → `rf_write = 1`, address 3, data BEEF for exactly one cycle after edge 2; `count` returns to 0.
- **Fill to full with `hold = 1`:** push 5 writes (r1..r5 = 0x0011..0x0055) → 4 accepted, `wb_ready = 0`, 5th ignored. Release `hold` → four consecutive `rf_write` pulses in order r1..r4, then `wb_ready = 1`.
- **Simultaneous push/pop with wrap-around:** hold `count` at 2 while pushing every cycle for 10 cycles (addresses 0..7,0,1) → `count` stays 2 and writes emerge in push order with no gaps.
- **Bypass (macro defined):** queue {r2 = 0x1111, r2 = 0x2222} with `hold = 1`, `rd_address_1 = 2`, `rf_read_data_1 = 0x0000` → `rd_data_1 = 0x2222`. `rd_address_2 = 5` → `rd_data_2 = rf_read_data_2`.
- **Bypass (macro undefined):** same stimulus → `rd_data_1 = 0x0000`.
- **Reset mid-drain:** 3 entries queued and draining, assert `reset_n = 0` between edges → `rf_write` drops immediately, `count = 0`, and no further writes occur after release.
